// File: rtl/arb_pkg.sv
// Shared encodings for the 2:1 round-robin arbiter and the mux stage it drives.
package arb_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_GNT0 = 2'd1;
  localparam logic [1:0] ST_GNT1 = 2'd2;

  localparam logic SEL_SRC0 = 1'b0;
  localparam logic SEL_SRC1 = 1'b1;

  // One-hot grant pattern implied by an FSM state.
  function automatic logic [1:0] grant_of(input logic [1:0] st);
    logic [1:0] g;
    case (st)
      ST_GNT0: g = 2'b01;
      ST_GNT1: g = 2'b10;
      default: g = 2'b00;
    endcase
    return g;
  endfunction

endpackage

// File: rtl/arb2x1_rr.sv
// Burst-based two-source round-robin arbiter; every output comes from a register.
module arb2x1_rr
  import arb_pkg::*;
#(
  parameter int BURST_MAX = 4,
  parameter int CNT_W     = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       req,
  input  logic [1:0]       last,
  output logic [1:0]       grant,
  output logic             sel,
  output logic             busy,
  output logic [CNT_W-1:0] burst_cnt
);

  localparam logic [CNT_W-1:0] CNT_CAP = CNT_W'(BURST_MAX - 1);

  logic [1:0]       state_r;
  logic [1:0]       state_n;
  logic [CNT_W-1:0] cnt_n;
  logic             prio_r;
  logic             prio_n;
  logic [1:0]       grant_n;
  logic             sel_n;
  logic             cur;
  logic             oth;
  logic             release_s;

  // State, prio and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r   <= ST_IDLE;
      prio_r    <= 1'b0;
      grant     <= 2'b00;
      sel       <= SEL_SRC0;
      busy      <= 1'b0;
      burst_cnt <= '0;
    end else begin
      state_r   <= state_n;
      prio_r    <= prio_n;
      grant     <= grant_n;
      sel       <= sel_n;
      busy      <= |grant_n;
      burst_cnt <= cnt_n;
    end
  end

  // Next-state, burst counter and priority update.
  always_comb begin
    state_n   = state_r;
    cnt_n     = burst_cnt;
    prio_n    = prio_r;
    cur       = (state_r == ST_GNT1);
    oth       = ~cur;
    release_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        cnt_n = '0;
        if (req == 2'b01) begin
          state_n = ST_GNT0;
        end else if (req == 2'b10) begin
          state_n = ST_GNT1;
        end else if (req == 2'b11) begin
          state_n = prio_r ? ST_GNT1 : ST_GNT0;
        end else begin
          state_n = ST_IDLE;
        end
      end
      ST_GNT0, ST_GNT1: begin
        // A dropped req wins over last; both simply end the burst.
        release_s = ~req[cur] | last[cur] | (burst_cnt == CNT_CAP);
        if (release_s) begin
          prio_n = oth;
          cnt_n  = '0;
          if (req[oth]) begin
            state_n = oth ? ST_GNT1 : ST_GNT0;
          end else if (req[cur]) begin
            state_n = state_r;
          end else begin
            state_n = ST_IDLE;
          end
        end else begin
          cnt_n   = burst_cnt + CNT_W'(1);
          state_n = state_r;
        end
      end
      default: begin
        state_n = ST_IDLE;
        cnt_n   = '0;
      end
    endcase
  end

  // Grant and select follow the next state; sel holds through idle.
  always_comb begin
    grant_n = grant_of(state_n);
    case (state_n)
      ST_GNT0: sel_n = SEL_SRC0;
      ST_GNT1: sel_n = SEL_SRC1;
      default: sel_n = sel;
    endcase
  end

endmodule

// File: tb/tb_arb2x1_rr.sv
// Randomised and directed checks of arb2x1_rr (BURST_MAX=4 and BURST_MAX=1) against a bench model.
module tb_arb2x1_rr;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] req;
  logic [1:0] last;
  logic [1:0] grant0, grant1;
  logic       sel0, sel1, busy0, busy1;
  logic [2:0] cnt0;
  logic [0:0] cnt1;

  int tests  = 0;
  int failed = 0;

  // Behavioural model: owner -1 means idle.
  int owner[2];
  int cnt[2];
  int prio[2];
  int lsel[2];
  int bm[2] = '{4, 1};

  logic [1:0] din = 2'b10;
  logic       dout;

  always #5 clk = ~clk;

  arb2x1_rr #(.BURST_MAX(4), .CNT_W(3)) u_arb4 (
    .clk(clk), .rst(rst), .req(req), .last(last),
    .grant(grant0), .sel(sel0), .busy(busy0), .burst_cnt(cnt0)
  );

  arb2x1_rr #(.BURST_MAX(1), .CNT_W(1)) u_arb1 (
    .clk(clk), .rst(rst), .req(req), .last(last),
    .grant(grant1), .sel(sel1), .busy(busy1), .burst_cnt(cnt1)
  );

  assign dout = din[sel0];

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      owner[i] = -1;
      cnt[i]   = 0;
      prio[i]  = 0;
      lsel[i]  = 0;
    end
  endtask

  task automatic model_step();
    for (int i = 0; i < 2; i++) begin
      if (owner[i] < 0) begin
        if (req == 2'b11)      owner[i] = prio[i];
        else if (req == 2'b01) owner[i] = 0;
        else if (req == 2'b10) owner[i] = 1;
        cnt[i] = 0;
      end else if (!req[owner[i]] || last[owner[i]] || cnt[i] == bm[i] - 1) begin
        prio[i] = 1 - owner[i];
        cnt[i]  = 0;
        if (req[1 - owner[i]])   owner[i] = 1 - owner[i];
        else if (!req[owner[i]]) owner[i] = -1;
      end else begin
        cnt[i] = cnt[i] + 1;
      end
      if (owner[i] >= 0) lsel[i] = owner[i];
    end
  endtask

  task automatic compare();
    chk("grant4", int'(grant0), owner[0] < 0 ? 0 : (1 << owner[0]));
    chk("sel4",   int'(sel0),   lsel[0]);
    chk("busy4",  int'(busy0),  owner[0] >= 0 ? 1 : 0);
    chk("cnt4",   int'(cnt0),   cnt[0]);
    chk("grant1", int'(grant1), owner[1] < 0 ? 0 : (1 << owner[1]));
    chk("sel1",   int'(sel1),   lsel[1]);
    chk("busy1",  int'(busy1),  owner[1] >= 0 ? 1 : 0);
    chk("cnt1",   int'(cnt1),   cnt[1]);
  endtask

  // Called at a negedge with inputs already driven; returns at the next negedge.
  task automatic cyc();
    @(posedge clk);
    model_step();
    @(negedge clk);
    compare();
  endtask

  task automatic reset_pulse();
    rst  = 1'b1;
    req  = 2'b00;
    last = 2'b00;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  initial begin
    logic [1:0] prev_grant;
    logic       prev_dout;
    rst  = 1'b1;
    req  = 2'b00;
    last = 2'b00;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    compare();
    chk("rst_grant", int'(grant0), 0);

    // Single requester, then drop.
    req = 2'b01;
    cyc();
    chk("single_g", int'(grant0), 1);
    chk("single_c0", int'(cnt0), 0);
    cyc();
    chk("single_c1", int'(cnt0), 1);
    req = 2'b00;
    cyc();
    chk("single_idle", int'(grant0), 0);
    chk("single_sel", int'(sel0), 0);

    // Contention: bursts of 4 (and strict alternation for BURST_MAX=1), mux follows grant.
    reset_pulse();
    req = 2'b11;
    prev_grant = 2'b00;
    prev_dout  = 1'b0;
    for (int k = 0; k < 16; k++) begin
      cyc();
      chk("cont_g4", int'(grant0), ((k / 4) % 2) ? 2 : 1);
      chk("cont_c4", int'(cnt0), k % 4);
      chk("cont_g1", int'(grant1), (k % 2) ? 2 : 1);
      chk("mux_dout", int'(dout), ((k / 4) % 2) ? 1 : 0);
      if (k > 0 && grant0 == prev_grant) chk("mux_stable", int'(dout), int'(prev_dout));
      prev_grant = grant0;
      prev_dout  = dout;
    end

    // Early last hands over with a fresh burst counter.
    reset_pulse();
    req = 2'b11;
    cyc();
    cyc();
    chk("early_c", int'(cnt0), 1);
    last = 2'b01;
    cyc();
    chk("early_g", int'(grant0), 2);
    chk("early_c0", int'(cnt0), 0);
    last = 2'b00;

    // Lone requester is re-granted with wrapping counter.
    reset_pulse();
    req = 2'b10;
    for (int k = 0; k < 10; k++) begin
      cyc();
      chk("regrant_g", int'(grant0), 2);
      chk("regrant_c", int'(cnt0), k % 4);
    end

    // Asynchronous reset in the middle of a GNT1 burst.
    @(posedge clk);
    #1 rst = 1'b1;
    #1;
    chk("arst_grant", int'(grant0), 0);
    chk("arst_sel", int'(sel0), 0);
    chk("arst_busy", int'(busy0), 0);
    chk("arst_cnt", int'(cnt0), 0);
    model_reset();
    req = 2'b00;
    @(negedge clk);
    rst = 1'b0;
    // Priority back to source 0 after reset.
    req = 2'b11;
    cyc();
    chk("arst_prio", int'(grant0), 1);

    // Randomised traffic with occasional resets.
    for (int k = 0; k < 1500; k++) begin
      if ($urandom_range(199, 0) == 0) begin
        reset_pulse();
        compare();
      end
      req  = 2'($urandom_range(3, 0));
      last = ($urandom_range(3, 0) == 0) ? 2'($urandom_range(3, 0)) : 2'b00;
      cyc();
      chk("inv_onehot", int'(grant0 == 2'b11 || grant1 == 2'b11), 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
